// File: rtl/vending_machine.sv
// ----------------------------------------------------------------------------
// vending_machine
//
// Purpose:
//   Controller for a 16-item snack machine laid out as rows A-D by columns
//   1-4. It watches a cumulative credit value from the coin acceptor and a
//   two-key (letter then number) selection. It shows the item price while
//   payment is pending. Once the credit covers the price it presents the
//   product index, the change and a success strobe to the dispenser. Idle
//   credit is refunded automatically after a timeout, and a reset refunds
//   it immediately.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset ("plug pulled")
//   money_input  in   16  cumulative credit in cents (environment zeroes it)
//   swa..swd     in   1   row keys A-D, active high
//   sw1..sw4     in   1   column keys 1-4, active high
//   change       out  16  cents to return
//   price        out  16  price of the selected item, cents
//   dispense     out  4   product index = row*4 + (col-1)
//   success      out  1   high while a vend result is presented
// ----------------------------------------------------------------------------
module vending_machine #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int DONE_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] money_input,
    input  logic        swa,
    input  logic        swb,
    input  logic        swc,
    input  logic        swd,
    input  logic        sw1,
    input  logic        sw2,
    input  logic        sw3,
    input  logic        sw4,
    output logic [15:0] change,
    output logic [15:0] price,
    output logic [3:0]  dispense,
    output logic        success
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DW = $clog2(DONE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LETTER,
        INVALID,
        CHECK,
        WAIT_MONEY,
        VEND,
        REFUND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    row;
    logic [1:0]    row_next;
    logic [1:0]    col;
    logic [1:0]    col_next;
    logic [7:0]    keys;
    logic [7:0]    keys_prev;
    logic [7:0]    edges;
    logic [15:0]   money_prev;
    logic [TW-1:0] timer;
    logic [DW-1:0] done_cnt;

    logic          any_edge;
    logic          one_edge;
    logic          single_letter;
    logic          single_number;
    logic          money_changed;
    logic          activity;
    logic          timed_state;
    logic          timeout_hit;
    logic          done_hit;
    logic [15:0]   item_price;
    logic          enough;

    // Converts a one-hot group of four keys into a 0-based position, where
    // the first key of the group (A or 1) sits in the most significant bit.
    function automatic logic [1:0] key_pos(input logic [3:0] k);
        if (k[3]) begin
            return 2'd0;
        end else if (k[2]) begin
            return 2'd1;
        end else if (k[1]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    // Key edges are taken against the previous cycle's sample, so holding a
    // key down counts as a single press. A selection is only meaningful when
    // exactly one key edge arrives in a cycle; several at once are invalid.
    assign keys          = {swa, swb, swc, swd, sw1, sw2, sw3, sw4};
    assign edges         = keys & ~keys_prev;
    assign any_edge      = |edges;
    assign one_edge      = any_edge && ((edges & (edges - 8'd1)) == 8'd0);
    assign single_letter = one_edge && (|edges[7:4]);
    assign single_number = one_edge && (|edges[3:0]);

    // The refund timer runs only while credit sits unused in one of the
    // waiting states. Any key edge or any change of credit counts as activity
    // and restarts it. The timeout fires after TIMEOUT_CYCLES idle cycles.
    assign money_changed = (money_input != money_prev);
    assign activity      = any_edge || money_changed;
    assign timed_state   = (state == IDLE) || (state == LETTER) ||
                           (state == INVALID) || (state == WAIT_MONEY);
    assign timeout_hit   = timed_state && (money_input != 16'd0) && !activity &&
                           (timer == TW'(TIMEOUT_CYCLES - 1));
    assign done_hit      = (done_cnt == DW'(DONE_CYCLES - 1));
    assign enough        = (money_input >= item_price);

    // Price lookup for the stored row/column selection, in cents.
    always_comb begin
        item_price = 16'd0;
        case ({row, col})
            4'd0:  item_price = 16'd100;
            4'd1:  item_price = 16'd125;
            4'd2:  item_price = 16'd150;
            4'd3:  item_price = 16'd75;
            4'd4:  item_price = 16'd250;
            4'd5:  item_price = 16'd200;
            4'd6:  item_price = 16'd225;
            4'd7:  item_price = 16'd175;
            4'd8:  item_price = 16'd50;
            4'd9:  item_price = 16'd100;
            4'd10: item_price = 16'd125;
            4'd11: item_price = 16'd150;
            4'd12: item_price = 16'd150;
            4'd13: item_price = 16'd175;
            4'd14: item_price = 16'd200;
            4'd15: item_price = 16'd300;
            default: item_price = 16'd0;
        endcase
    end

    // Next-state logic. A letter always starts a fresh selection from IDLE,
    // INVALID or WAIT_MONEY. While a result is presented (VEND/REFUND) keys
    // are ignored and the machine simply counts down DONE_CYCLES.
    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        case (state)
            IDLE: begin
                if (timeout_hit) begin
                    state_next = REFUND;
                end else if (single_letter) begin
                    state_next = LETTER;
                    row_next   = key_pos(edges[7:4]);
                end else if (any_edge) begin
                    state_next = INVALID;
                end
            end
            LETTER: begin
                if (timeout_hit) begin
                    state_next = REFUND;
                end else if (single_number) begin
                    state_next = CHECK;
                    col_next   = key_pos(edges[3:0]);
                end else if (any_edge) begin
                    state_next = INVALID;
                end
            end
            INVALID: begin
                if (timeout_hit) begin
                    state_next = REFUND;
                end else if (single_letter) begin
                    state_next = LETTER;
                    row_next   = key_pos(edges[7:4]);
                end
            end
            CHECK: begin
                state_next = enough ? VEND : WAIT_MONEY;
            end
            WAIT_MONEY: begin
                if (enough) begin
                    state_next = VEND;
                end else if (timeout_hit) begin
                    state_next = REFUND;
                end else if (single_letter) begin
                    state_next = LETTER;
                    row_next   = key_pos(edges[7:4]);
                end
            end
            VEND, REFUND: begin
                if (done_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode. While reset is held the whole credit is handed back
    // combinationally, so pulling the plug never swallows money. Change in
    // VEND is only formed when the credit covers the price.
    always_comb begin
        change   = 16'd0;
        price    = 16'd0;
        dispense = 4'd0;
        success  = 1'b0;
        if (reset) begin
            change = money_input;
        end else begin
            case (state)
                CHECK, WAIT_MONEY: begin
                    price = item_price;
                end
                VEND: begin
                    success  = 1'b1;
                    dispense = {row, col};
                    price    = item_price;
                    change   = enough ? (money_input - item_price) : 16'd0;
                end
                REFUND: begin
                    change = money_input;
                end
                default: begin
                    change = 16'd0;
                end
            endcase
        end
    end

    // State, selection, edge-detect history and the two counters. The timer
    // is held at zero outside the waiting states, with no credit, or on
    // activity. The done counter only advances while a result is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row        <= 2'd0;
            col        <= 2'd0;
            keys_prev  <= 8'd0;
            money_prev <= 16'd0;
            timer      <= '0;
            done_cnt   <= '0;
        end else begin
            state      <= state_next;
            row        <= row_next;
            col        <= col_next;
            keys_prev  <= keys;
            money_prev <= money_input;
            if (!timed_state || (money_input == 16'd0) || activity) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if ((state == VEND) || (state == REFUND)) begin
                done_cnt <= done_hit ? '0 : done_cnt + DW'(1);
            end else begin
                done_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vending_machine.sv
// ----------------------------------------------------------------------------
// tb_vending_machine
//
// Purpose:
//   Self-checking bench for vending_machine. Directed scenarios cover pay
//   first, select first, overpay, underpay, invalid and multi-key selections,
//   timeout refund and reset refund. These are followed by randomized
//   transactions. Expected results come from a transaction-level view: the
//   price table, credit minus price, and fixed hold and timeout lengths.
// ----------------------------------------------------------------------------
module tb_vending_machine;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int DONE_CYCLES    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] moneyInput;
    logic        swa, swb, swc, swd;
    logic        sw1, sw2, sw3, sw4;
    logic [15:0] change;
    logic [15:0] price;
    logic [3:0]  dispense;
    logic        success;

    int checkCount = 0;
    int errorCount = 0;

    // Item prices in cents, indexed by row*4 + column (A1 first, D4 last).
    int priceTable [16] = '{100, 125, 150, 75,
                            250, 200, 225, 175,
                             50, 100, 125, 150,
                            150, 175, 200, 300};

    vending_machine #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .DONE_CYCLES   (DONE_CYCLES)
    ) dut (
        .clk        (clock),
        .reset      (reset),
        .money_input(moneyInput),
        .swa        (swa),
        .swb        (swb),
        .swc        (swc),
        .swd        (swd),
        .sw1        (sw1),
        .sw2        (sw2),
        .sw3        (sw3),
        .sw4        (sw4),
        .change     (change),
        .price      (price),
        .dispense   (dispense),
        .success    (success)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Safety net in case the design wedges somewhere the bounded waits miss.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock; everything is driven and sampled 2 units after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic setKeys(input logic [7:0] k);
        {swa, swb, swc, swd, sw1, sw2, sw3, sw4} = k;
    endtask

    // One key press: keys high for one cycle, then released for one cycle.
    task automatic applyStimulus(input logic [7:0] k);
        setKeys(k);
        tick();
        setKeys(8'h00);
        tick();
    endtask

    function automatic logic [7:0] letterKey(input int r);
        logic [7:0] base;
        base = 8'h80;
        return base >> r;
    endfunction

    function automatic logic [7:0] numberKey(input int c);
        logic [7:0] base;
        base = 8'h08;
        return base >> c;
    endfunction

    task automatic selectItem(input int r, input int c);
        applyStimulus(letterKey(r));
        applyStimulus(numberKey(c));
    endtask

    task automatic expectWaiting(input string tag, input int prc);
        checkOutput({tag, "_price"}, price, prc);
        checkOutput({tag, "_success"}, success, 0);
        checkOutput({tag, "_change"}, change, 0);
    endtask

    // Waits (bounded) for a vend. It then checks the presented result and
    // that it is held for DONE_CYCLES. Finally it clears credit the way the
    // payout logic would.
    task automatic expectVend(input string tag, input int idx, input int chg, input int prc);
        int waited;
        int held;
        waited = 0;
        held   = 0;
        while (success !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_success"}, success, 1);
        if (success === 1'b1) begin
            checkOutput({tag, "_dispense"}, dispense, idx);
            checkOutput({tag, "_change"}, change, chg);
            checkOutput({tag, "_price"}, price, prc);
            while (success === 1'b1 && held < DONE_CYCLES + 4) begin
                held++;
                tick();
            end
            checkOutput({tag, "_hold"}, held, DONE_CYCLES);
            checkOutput({tag, "_after_change"}, change, 0);
        end
        moneyInput = 16'd0;
        tick();
        tick();
    endtask

    task automatic expectRefund(input string tag, input int amount);
        int held;
        held = 0;
        checkOutput({tag, "_change"}, change, amount);
        checkOutput({tag, "_success"}, success, 0);
        checkOutput({tag, "_dispense"}, dispense, 0);
        checkOutput({tag, "_price"}, price, 0);
        while (change != 16'd0 && held < DONE_CYCLES + 4) begin
            held++;
            tick();
        end
        checkOutput({tag, "_hold"}, held, DONE_CYCLES);
        moneyInput = 16'd0;
        tick();
        tick();
    endtask

    initial begin
        int waited;
        reset      = 1'b1;
        moneyInput = 16'd0;
        setKeys(8'h00);

        // Reset state and combinational full refund while reset is held.
        #12;
        checkOutput("reset_price", price, 0);
        checkOutput("reset_dispense", dispense, 0);
        checkOutput("reset_success", success, 0);
        checkOutput("reset_change_zero", change, 0);
        moneyInput = 16'd100;
        #1;
        checkOutput("reset_refund", change, 100);
        moneyInput = 16'd0;
        tick();
        reset = 1'b0;
        tick();

        // Pay first: credit climbs 25 at a time to exactly the A2 price.
        for (int m = 25; m <= 125; m += 25) begin
            moneyInput = 16'(m);
            tick();
        end
        selectItem(0, 1);
        expectVend("payfirst", 1, 0, 125);

        // Select first: B4 shows its price until the credit reaches it.
        selectItem(1, 3);
        tick();
        expectWaiting("selfirst_wait0", 175);
        moneyInput = 16'd100;
        tick();
        tick();
        expectWaiting("selfirst_wait100", 175);
        moneyInput = 16'd175;
        expectVend("selfirst", 7, 0, 175);

        // Overpay on A3.
        moneyInput = 16'd200;
        tick();
        selectItem(0, 2);
        expectVend("overpay", 2, 50, 150);

        // Underpay on B1, then top up past the price.
        moneyInput = 16'd200;
        tick();
        selectItem(1, 0);
        tick();
        expectWaiting("underpay", 250);
        moneyInput = 16'd300;
        expectVend("underpay_topup", 4, 50, 250);

        // Invalid selection A, A, 4, 4, then a proper A4 selection.
        applyStimulus(letterKey(0));
        applyStimulus(letterKey(0));
        applyStimulus(numberKey(3));
        applyStimulus(numberKey(3));
        checkOutput("invalid_price", price, 0);
        checkOutput("invalid_success", success, 0);
        moneyInput = 16'd200;
        tick();
        selectItem(0, 3);
        expectVend("invalid_recover", 3, 125, 75);

        // Two letters pressed together is invalid; the following number must not select.
        applyStimulus(letterKey(0) | letterKey(1));
        applyStimulus(numberKey(0));
        tick();
        checkOutput("multikey_price", price, 0);
        checkOutput("multikey_success", success, 0);

        // Timeout: credit left idle for TIMEOUT_CYCLES cycles after it arrived.
        moneyInput = 16'd100;
        tick();
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
            tick();
        end
        checkOutput("timeout_early", change, 0);
        tick();
        expectRefund("timeout", 100);

        // Randomized transactions in either order with random credit.
        for (int t = 0; t < 30; t++) begin
            int r;
            int c;
            int idx;
            int p;
            int m;
            int extra;
            int payFirst;
            r        = int'($urandom_range(0, 3));
            c        = int'($urandom_range(0, 3));
            idx      = r * 4 + c;
            p        = priceTable[idx];
            m        = int'($urandom_range(0, 80)) * 5;
            extra    = int'($urandom_range(0, 20)) * 5;
            payFirst = int'($urandom_range(0, 1));
            if (payFirst == 1) begin
                moneyInput = 16'(m);
                tick();
                selectItem(r, c);
            end else begin
                selectItem(r, c);
                tick();
                expectWaiting("rand_selfirst", p);
                moneyInput = 16'(m);
            end
            if (m >= p) begin
                expectVend("rand_vend", idx, m - p, p);
            end else begin
                tick();
                tick();
                expectWaiting("rand_wait", p);
                moneyInput = 16'(p + extra);
                expectVend("rand_topup", idx, extra, p);
            end
        end

        // Reset in the middle of a vend aborts it and refunds the credit.
        moneyInput = 16'd200;
        tick();
        selectItem(0, 2);
        waited = 0;
        while (success !== 1'b1 && waited < 12) begin
            tick();
            waited++;
        end
        checkOutput("midvend_success", success, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midvend_reset_success", success, 0);
        checkOutput("midvend_reset_change", change, 200);
        checkOutput("midvend_reset_dispense", dispense, 0);
        checkOutput("midvend_reset_price", price, 0);
        tick();
        checkOutput("midvend_reset_held", change, 200);
        moneyInput = 16'd0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_reset_change", change, 0);
        checkOutput("post_reset_success", success, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
